// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
// Package : eth_pkg
// Shared constants, types and CRC-32 step function for the Ethernet RX path.
// Rev     : 1.0
// ============================================================================
package eth_pkg;

    localparam logic [7:0]  c_preamble    = 8'h55;
    localparam logic [7:0]  c_sfd         = 8'hD5;
    localparam int          c_hdr_len     = 14;
    localparam int          c_fcs_len     = 4;
    localparam logic [31:0] c_crc_poly    = 32'hEDB88320;
    localparam logic [31:0] c_crc_init    = 32'hFFFFFFFF;
    localparam logic [31:0] c_crc_residue = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_HEADER   = 3'd2,
        ST_PAYLOAD  = 3'd3,
        ST_DISCARD  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_RUNT = 2'd1,
        ERR_LONG = 2'd2,
        ERR_FCS  = 2'd3
    } err_code_t;

    typedef logic [47:0] mac_t;

    // Reflected CRC-32, one byte, LSB of the byte first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ c_crc_poly) : (c >> 1);
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eth_crc32.sv
`default_nettype none
// ============================================================================
// Module : eth_crc32
// Byte-wide CRC-32 register with combinational next value; clear wins over enable.
// Rev    : 1.0
// ============================================================================
module eth_crc32
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc_nxt
);

    logic [31:0] r_crc;

    assign crc_nxt = crc32_byte(r_crc, data);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_crc <= c_crc_init;
        end else if (en) begin
            r_crc <= crc_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/eth_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module : eth_rx_ctrl
// Ethernet RX sequencer: preamble hunt, header extract, FCS strip.
// FCS checking is built only when ETH_RX_FCS_CHECK_EN is defined.
// Rev    : 1.0
// ============================================================================
module eth_rx_ctrl
    import eth_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_vld,
    input  logic        in_last,
    output logic        ready,
    output logic        hdr_vld,
    output logic [47:0] dst_mac,
    output logic [47:0] src_mac,
    output logic [15:0] ethertype,
    output logic [7:0]  pl_data,
    output logic        pl_vld,
    output logic        pl_last,
    output logic        frame_done,
    output logic        frame_err,
    output logic [1:0]  err_code
);

    state_t      r_state;
    logic [10:0] r_len;
    logic [2:0]  r_fill;
    logic [7:0]  r_dly [c_fcs_len];

    logic [10:0] w_len_nxt;
    logic        w_long;
    logic        w_fcs_ok;

    assign w_len_nxt = (r_len == 11'h7FF) ? r_len : r_len + 11'd1;
    assign w_long    = (w_len_nxt == 11'(MAX_LEN + 1));

`ifdef ETH_RX_FCS_CHECK_EN
    logic [31:0] w_crc_nxt;
    logic        w_crc_clr;
    logic        w_crc_en;

    assign w_crc_clr = in_vld && (r_state == ST_PREAMBLE) && (in_data == c_sfd);
    assign w_crc_en  = in_vld && ((r_state == ST_HEADER) || (r_state == ST_PAYLOAD));
    assign w_fcs_ok  = (w_crc_nxt == c_crc_residue);

    eth_crc32 u_crc (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_crc_clr),
        .en      (w_crc_en),
        .data    (in_data),
        .crc_nxt (w_crc_nxt)
    );
`else
    assign w_fcs_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_len      <= 11'd0;
            r_fill     <= 3'd0;
            ready      <= 1'b1;
            hdr_vld    <= 1'b0;
            dst_mac    <= 48'h0;
            src_mac    <= 48'h0;
            ethertype  <= 16'h0;
            pl_data    <= 8'h0;
            pl_vld     <= 1'b0;
            pl_last    <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= ERR_NONE;
            for (int i = 0; i < c_fcs_len; i++) r_dly[i] <= 8'h0;
        end else begin
            hdr_vld    <= 1'b0;
            pl_vld     <= 1'b0;
            pl_last    <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= ERR_NONE;
            if (in_vld) begin
                case (r_state)
                    ST_IDLE: begin
                        if (in_data == c_preamble) begin
                            r_state <= ST_PREAMBLE;
                            ready   <= 1'b0;
                        end
                    end
                    ST_PREAMBLE: begin
                        if (in_last || ((in_data != c_preamble) && (in_data != c_sfd))) begin
                            r_state <= ST_IDLE;
                            ready   <= 1'b1;
                        end else if (in_data == c_sfd) begin
                            r_state <= ST_HEADER;
                            r_len   <= 11'd0;
                            r_fill  <= 3'd0;
                        end
                    end
                    ST_HEADER: begin
                        r_len <= w_len_nxt;
                        {dst_mac, src_mac, ethertype} <= {dst_mac[39:0], src_mac, ethertype, in_data};
                        if (w_long) begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_LONG;
                            r_state   <= in_last ? ST_IDLE : ST_DISCARD;
                            ready     <= in_last;
                        end else if (in_last) begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_RUNT;
                            r_state   <= ST_IDLE;
                            ready     <= 1'b1;
                        end else if (w_len_nxt == 11'(c_hdr_len)) begin
                            hdr_vld <= 1'b1;
                            r_state <= ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        r_len <= w_len_nxt;
                        if (w_long) begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_LONG;
                            r_state   <= in_last ? ST_IDLE : ST_DISCARD;
                            ready     <= in_last;
                        end else begin
                            r_dly[0] <= in_data;
                            for (int i = 1; i < c_fcs_len; i++) r_dly[i] <= r_dly[i-1];
                            if (r_fill != 3'(c_fcs_len)) r_fill <= r_fill + 3'd1;
                            // Oldest entry leaves only once the line holds a full FCS behind it.
                            if (r_fill == 3'(c_fcs_len)) begin
                                pl_vld  <= 1'b1;
                                pl_data <= r_dly[c_fcs_len-1];
                                pl_last <= in_last;
                            end
                            if (in_last) begin
                                r_state <= ST_IDLE;
                                ready   <= 1'b1;
                                if ((r_fill != 3'(c_fcs_len)) || (w_len_nxt < 11'(MIN_LEN))) begin
                                    frame_err <= 1'b1;
                                    err_code  <= ERR_RUNT;
                                end else if (!w_fcs_ok) begin
                                    frame_err <= 1'b1;
                                    err_code  <= ERR_FCS;
                                end else begin
                                    frame_done <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_DISCARD: begin
                        if (in_last) begin
                            r_state <= ST_IDLE;
                            ready   <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        ready   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/eth_rx_ctrl.md
# eth_rx_ctrl

Byte-wide Ethernet receive sequencer between the PHY-side byte stream and the receive datapath. Hunts for preamble/SFD, extracts the 14-byte MAC header, and forwards the payload with the 4-byte FCS stripped. Optionally checks the FCS. Reports per-frame completion or error so downstream logic can commit or drop the frame.

## Interface
- `MIN_LEN`, default 64: minimum frame length in bytes, counted from the first byte after SFD through the last FCS byte.
- `MAX_LEN`, default 1518: maximum frame length, same counting; must be ≤ 2046.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `in_data` in 8: received byte.
- `in_vld` in 1: `in_data` valid this cycle; no backpressure.
- `in_last` in 1: qualifies the final byte of a frame (last FCS byte).
- `ready` out 1: high while idle and hunting for preamble.
- `hdr_vld` out 1: one-cycle pulse; header fields are valid.
- `dst_mac` out 48: destination MAC; the first received byte is in [47:40].
- `src_mac` out 48: source MAC, same byte order.
- `ethertype` out 16: EtherType; the first received byte is in [15:8].
- `pl_data` out 8: payload byte.
- `pl_vld` out 1: `pl_data` valid.
- `pl_last` out 1: last payload byte of the frame.
- `frame_done` out 1: one-cycle pulse; frame accepted.
- `frame_err` out 1: one-cycle pulse; frame must be dropped.
- `err_code` out 2: valid with `frame_err`. Codes: 1 = RUNT, 2 = LONG, 3 = FCS.

## Operation
- **States:** IDLE, PREAMBLE, HEADER, PAYLOAD, DISCARD.
- **IDLE:**
  - `in_vld` with 0x55 → PREAMBLE.
  - Any other byte is ignored.
- **PREAMBLE:**
  - 0x55 → stay.
  - 0xD5 (SFD) → HEADER; clear the length counter.
  - Any other byte, or `in_last` → IDLE with no report.
- **HEADER:**
  - Shifts 14 bytes into `dst_mac`, `src_mac`, `ethertype`.
  - After the 14th byte → PAYLOAD.
  - `in_last` before the 14th byte → `frame_err` RUNT, then IDLE.
- **PAYLOAD:**
  - Each byte enters a 4-entry delay line.
  - Once the line is full, each new byte pushes the oldest out as `pl_data`.
  - The bytes left in the line at `in_last` are the FCS and are never output.
- **Length counter:**
  - 11-bit, saturating, counts every byte after SFD.
  - When the count reaches `MAX_LEN`+1: `frame_err` LONG, no `pl_last`, `pl_vld` stops, go to DISCARD.
- **DISCARD:** ignores input until `in_last`, then IDLE.
- **On `in_last` in PAYLOAD:**
  - The oldest delay-line byte is output with `pl_last`=1.
  - In the same cycle, either `frame_done` or `frame_err` pulses:
    - length < `MIN_LEN` → RUNT;
    - FCS mismatch (when enabled) → FCS;
    - otherwise → `frame_done`.
  - If fewer than 4 payload-phase bytes arrived, no `pl_vld` is produced and RUNT is reported.
- **Termination invariant:** every frame that reaches HEADER ends with exactly one `frame_done` or `frame_err`.
- **Input gaps:** `in_vld` low stalls everything; no state change.
- **Back-to-back frames:** the cycle after `in_last` the block is in IDLE, so a 0x55 there is accepted.
- **Reset values:**
  - all outputs 0 except `ready`=1;
  - state IDLE, delay line and counter cleared.
- **Reset mid-frame:** abandons the frame with no error pulse.

## Timing
- All outputs are registered.
- Each response appears the cycle after the `in_vld` cycle that caused it.
- `hdr_vld` pulses the cycle after the 14th header byte; the header fields hold until the next SFD.
- Payload latency: payload byte k is output the cycle after byte k+4 of the payload phase is accepted.
- `ready` falls the cycle after the first 0x55 and rises the cycle after the frame terminates or aborts.

## Configuration
- **`ETH_RX_FCS_CHECK_EN` defined:**
  - A reflected CRC-32 (poly 32'hEDB88320, init 32'hFFFFFFFF) runs over all bytes after SFD, including the FCS.
  - At `in_last` the updated register must equal the residue 32'hDEBB20E3; otherwise `frame_err` FCS.
  - RUNT and LONG take priority over FCS.
- **Undefined:**
  - The FCS is stripped but not checked; code 3 is never produced.
  - The CRC sub-module is not instantiated.

## Structure
- **Shared package `eth_pkg`:**
  - constants: preamble byte 8'h55, SFD 8'hD5, header length 14, FCS length 4, CRC polynomial, init, residue;
  - typedefs: state enum, `err_code` enum, 48-bit MAC type.
- **Sub-module `eth_crc32`:** byte-wide combinational next-CRC plus a register, with clear and enable inputs.

## Test plan
- **Good frame:**
  - Stimulus: 7×0x55, 0xD5, dst FF:FF:FF:FF:FF:FF, src 00:11:22:33:44:55, type 0x0800, payload 0x00..0x2D (46 bytes), correct FCS.
  - Response: `hdr_vld` with dst 48'hFFFFFFFFFFFF, src 48'h001122334455, type 16'h0800; 46 `pl_vld` bytes 0x00..0x2D; `pl_last` on 0x2D with `frame_done`.
- **Runt:**
  - Stimulus: header + 10 payload bytes + FCS (28 bytes).
  - Response: 10 payload bytes, `pl_last` on the 10th, `frame_err` with code 1.
- **Long:**
  - Stimulus: `MAX_LEN`=100, 200-byte frame.
  - Response: `frame_err` code 2 after the 101st byte; no further `pl_vld` or `pl_last`; the next frame parses normally.
- **Bad FCS:**
  - Stimulus: good frame with one FCS bit flipped.
  - Response with macro: `pl_last` + `frame_err` code 3.
  - Response without macro: `pl_last` + `frame_done`.
- **Preamble abort:**
  - Stimulus: 0x55 0x55 0x12, then a good frame.
  - Response: no outputs for the aborted bytes, `ready` back to 1; the good frame is fully parsed.
- **Reset and back-to-back:**
  - Stimulus: `rst` mid-payload, then two good frames with no idle cycle between them, with random `in_vld` gaps.
  - Response: no pulse for the aborted frame; two `frame_done` pulses with correct payloads.
